// File: rtl/sort_pkg.sv
// Shared lane type, width constants and compare helpers for the bitonic sorting network.
// Latency: none (types and combinational functions only).
// Backpressure: none; flow control lives in bitonic_sort_pipe.
// Contents: NETWORK_WIDTH/INDEX_WIDTH build widths, sort_lane_t, stage_count(), key_greater().
package sort_pkg;

    // Build-wide key and payload widths shared by the sorting subsystem.
    localparam int NETWORK_WIDTH = 16;
    localparam int INDEX_WIDTH   = 8;

    typedef struct packed {
        logic [NETWORK_WIDTH-1:0] data;
        logic [INDEX_WIDTH-1:0]   index;
    } sort_lane_t;

    // Number of compare-exchange layers for 2**log_n lanes.
    function automatic int stage_count(input int log_n);
        return (log_n * (log_n + 1)) / 2;
    endfunction

    // True when key a orders after key b. Index breaks ties only when enabled,
    // so with tie_index clear equal keys are never reported as greater.
    function automatic logic key_greater(
        input logic [NETWORK_WIDTH-1:0] data_a,
        input logic [INDEX_WIDTH-1:0]   idx_a,
        input logic [NETWORK_WIDTH-1:0] data_b,
        input logic [INDEX_WIDTH-1:0]   idx_b,
        input bit                       is_signed,
        input bit                       tie_index
    );
        logic data_gt;
        logic data_eq;
        if (is_signed) begin
            data_gt = $signed(data_a) > $signed(data_b);
        end else begin
            data_gt = data_a > data_b;
        end
        data_eq = (data_a == data_b);
        return data_gt || (tie_index && data_eq && (idx_a > idx_b));
    endfunction

endpackage

// File: rtl/bitonic_layer.sv
// One combinational compare-exchange layer (k, j) of the bitonic network.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent pipeline registers and stalls around it.
// Ports: desc selects descending order, lanes_in/lanes_out are the N {data,index} lanes.
module bitonic_layer
    import sort_pkg::*;
#(
    parameter int LOG_N     = 3,
    parameter int K         = 1,
    parameter int J         = 0,
    parameter int SIGNED    = 0,
    parameter int TIE_INDEX = 1
) (
    input  logic                          desc,
    input  sort_lane_t [(1<<LOG_N)-1:0]   lanes_in,
    output sort_lane_t [(1<<LOG_N)-1:0]   lanes_out
);

    localparam int N = 1 << LOG_N;

    // Each lane with bit J clear owns the pair (i, i + 2**J); its partner has
    // bit J set and is driven from the owner's block.
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (((i >> J) & 1) == 0) begin : g_pair
            localparam int P = i + (1 << J);
            // Bit K of the lane picks the half-sequence direction; the final
            // merge (K == LOG_N) is always a single ascending run before desc.
            localparam bit ASC_BASE = (K == LOG_N) || (((i >> K) & 1) == 0);

            logic asc;
            logic a_gt;
            logic b_gt;
            logic swap;

            assign asc  = ASC_BASE ^ desc;
            assign a_gt = key_greater(lanes_in[i].data, lanes_in[i].index,
                                      lanes_in[P].data, lanes_in[P].index,
                                      SIGNED != 0, TIE_INDEX != 0);
            assign b_gt = key_greater(lanes_in[P].data, lanes_in[P].index,
                                      lanes_in[i].data, lanes_in[i].index,
                                      SIGNED != 0, TIE_INDEX != 0);
            assign swap = asc ? a_gt : b_gt;

            assign lanes_out[i] = swap ? lanes_in[P] : lanes_in[i];
            assign lanes_out[P] = swap ? lanes_in[i] : lanes_in[P];
        end
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter for 2**LOG_N {data,index} lanes, one vector per cycle.
// Latency: S = LOG_N*(LOG_N+1)/2 cycles from input accept to out_valid.
// Backpressure: global stall; all stages hold when out_valid && !out_ready, in_ready = advance.
// Ports: in_valid/in_ready/in_desc/in_data/in_index in, out_valid/out_ready/out_desc/out_data/out_index out, busy.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter int LOG_N     = 3,
    parameter int SIGNED    = 0,
    parameter int TIE_INDEX = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_desc,
    input  logic [(1<<LOG_N)-1:0][NETWORK_WIDTH-1:0]    in_data,
    input  logic [(1<<LOG_N)-1:0][INDEX_WIDTH-1:0]      in_index,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_desc,
    output logic [(1<<LOG_N)-1:0][NETWORK_WIDTH-1:0]    out_data,
    output logic [(1<<LOG_N)-1:0][INDEX_WIDTH-1:0]      out_index,
    output logic                                        busy
);

    localparam int N = 1 << LOG_N;
    localparam int S = stage_count(LOG_N);

    logic [S-1:0]       stg_valid;
    logic [S-1:0]       stg_desc;
    sort_lane_t [N-1:0] stg_lane [S];

    sort_lane_t [N-1:0] in_lane;
    sort_lane_t [N-1:0] lay_in   [S];
    sort_lane_t [N-1:0] lay_out  [S];
    logic [S-1:0]       lay_desc;

    logic advance;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_lane[i].data  = in_data[i];
            in_lane[i].index = in_index[i];
        end
    end

    // Stage index for (k, j): layers run k = 1..LOG_N, j = k-1 down to 0.
    for (genvar k = 1; k <= LOG_N; k++) begin : g_k
        for (genvar jj = 0; jj < k; jj++) begin : g_j
            localparam int SI = ((k - 1) * k) / 2 + jj;

            if (SI == 0) begin : g_first
                assign lay_in[SI]   = in_lane;
                assign lay_desc[SI] = in_desc;
            end else begin : g_next
                assign lay_in[SI]   = stg_lane[SI-1];
                assign lay_desc[SI] = stg_desc[SI-1];
            end

            bitonic_layer #(
                .LOG_N     (LOG_N),
                .K         (k),
                .J         (k - 1 - jj),
                .SIGNED    (SIGNED),
                .TIE_INDEX (TIE_INDEX)
            ) u_layer (
                .desc      (lay_desc[SI]),
                .lanes_in  (lay_in[SI]),
                .lanes_out (lay_out[SI])
            );
        end
    end

    // A single stall signal freezes every stage; bubbles are not squeezed out,
    // which keeps the control to one gate and the latency fixed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_desc  <= '0;
            for (int s = 0; s < S; s++) begin
                stg_lane[s] <= '0;
            end
        end else if (advance) begin
            stg_valid[0] <= in_valid;
            for (int s = 1; s < S; s++) begin
                stg_valid[s] <= stg_valid[s-1];
            end
            for (int s = 0; s < S; s++) begin
                stg_desc[s] <= lay_desc[s];
                stg_lane[s] <= lay_out[s];
            end
        end
    end

    assign out_valid = stg_valid[S-1];
    assign out_desc  = stg_desc[S-1];
    assign busy      = |stg_valid;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_data[i]  = stg_lane[S-1][i].data;
            out_index[i] = stg_lane[S-1][i].index;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe: three instances (default, no index tie-break, signed)
// driven in lockstep, checked against a queue of accepted vectors and an insertion-sort model.
// Directed cases cover reset, latency, direction, ties, signed order, stall hold and mid-flight reset.
module tb_bitonic_sort_pipe;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int IW = 8;

    typedef struct packed {
        logic                   desc;
        logic [N-1:0][DW-1:0]   d;
        logic [N-1:0][IW-1:0]   x;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_desc = 1'b0;
    logic out_ready = 1'b1;
    logic [N-1:0][DW-1:0] in_data = '0;
    logic [N-1:0][IW-1:0] in_index = '0;

    logic a_in_ready, a_out_valid, a_out_desc, a_busy;
    logic b_in_ready, b_out_valid, b_out_desc, b_busy;
    logic c_in_ready, c_out_valid, c_out_desc, c_busy;
    logic [N-1:0][DW-1:0] a_out_data, b_out_data, c_out_data;
    logic [N-1:0][IW-1:0] a_out_index, b_out_index, c_out_index;

    always #5 clk = ~clk;

    bitonic_sort_pipe #(.LOG_N(3), .SIGNED(0), .TIE_INDEX(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_desc(in_desc), .in_data(in_data), .in_index(in_index),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_desc(a_out_desc),
        .out_data(a_out_data), .out_index(a_out_index), .busy(a_busy)
    );

    bitonic_sort_pipe #(.LOG_N(3), .SIGNED(0), .TIE_INDEX(0)) u_dut_notie (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_desc(in_desc), .in_data(in_data), .in_index(in_index),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_desc(b_out_desc),
        .out_data(b_out_data), .out_index(b_out_index), .busy(b_busy)
    );

    bitonic_sort_pipe #(.LOG_N(3), .SIGNED(1), .TIE_INDEX(1)) u_dut_sgn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_desc(in_desc), .in_data(in_data), .in_index(in_index),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_desc(c_out_desc),
        .out_data(c_out_data), .out_index(c_out_index), .busy(c_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference ordering: keys become plain integers, ties go to the index.
    function automatic bit ref_gt(input logic [DW-1:0] da, input logic [IW-1:0] xa,
                                  input logic [DW-1:0] db, input logic [IW-1:0] xb,
                                  input bit sgn, input bit tie);
        int ka;
        int kb;
        ka = int'(da);
        kb = int'(db);
        if (sgn && ka >= 32768) ka = ka - 65536;
        if (sgn && kb >= 32768) kb = kb - 65536;
        return (ka > kb) || (tie && ka == kb && xa > xb);
    endfunction

    task automatic ref_sort(input vec_t v, input bit sgn, input bit tie,
                            output logic [N-1:0][DW-1:0] od, output logic [N-1:0][IW-1:0] ox);
        logic [DW-1:0] d [N];
        logic [IW-1:0] x [N];
        logic [DW-1:0] td;
        logic [IW-1:0] tx;
        for (int i = 0; i < N; i++) begin
            d[i] = v.d[i];
            x[i] = v.x[i];
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (!ref_gt(d[j-1], x[j-1], d[j], x[j], sgn, tie)) break;
                td = d[j]; d[j] = d[j-1]; d[j-1] = td;
                tx = x[j]; x[j] = x[j-1]; x[j-1] = tx;
            end
        end
        for (int i = 0; i < N; i++) begin
            od[i] = v.desc ? d[N-1-i] : d[i];
            ox[i] = v.desc ? x[N-1-i] : x[i];
        end
    endtask

    // Scoreboard and stall monitor, sampled on the falling edge.
    vec_t exp_q[$];
    logic                 stall_prev = 1'b0;
    logic [N-1:0][DW-1:0] hold_d;
    logic [N-1:0][IW-1:0] hold_x;
    logic                 hold_desc;

    always @(negedge clk) begin
        vec_t nv;
        vec_t v;
        logic [N-1:0][DW-1:0] ed;
        logic [N-1:0][IW-1:0] ex;
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_data",  128'(a_out_data),  128'(hold_d));
                chk("stall_index", 128'(a_out_index), 128'(hold_x));
                chk("stall_desc",  128'(a_out_desc),  128'(hold_desc));
            end
            if (a_out_valid && !out_ready) chk("stall_in_ready", 128'(a_in_ready), 128'(0));
            if (in_valid && a_in_ready) begin
                nv.desc = in_desc;
                nv.d    = in_data;
                nv.x    = in_index;
                exp_q.push_back(nv);
            end
            if (a_out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 128'(1), 128'(0));
                end else begin
                    v = exp_q.pop_front();
                    ref_sort(v, 1'b0, 1'b1, ed, ex);
                    chk("a_data",  128'(a_out_data),  128'(ed));
                    chk("a_index", 128'(a_out_index), 128'(ex));
                    chk("a_desc",  128'(a_out_desc),  128'(v.desc));
                    ref_sort(v, 1'b0, 1'b0, ed, ex);
                    chk("b_valid", 128'(b_out_valid), 128'(1));
                    chk("b_data",  128'(b_out_data),  128'(ed));
                    ref_sort(v, 1'b1, 1'b1, ed, ex);
                    chk("c_valid", 128'(c_out_valid), 128'(1));
                    chk("c_data",  128'(c_out_data),  128'(ed));
                    chk("c_index", 128'(c_out_index), 128'(ex));
                end
            end
            stall_prev = a_out_valid && !out_ready;
            hold_d     = a_out_data;
            hold_x     = a_out_index;
            hold_desc  = a_out_desc;
        end
    end

    task automatic send(input logic desc, input logic [N-1:0][DW-1:0] d, input logic [N-1:0][IW-1:0] x);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_desc  = desc;
        in_data  = d;
        in_index = x;
        @(negedge clk);
        while (!a_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!a_in_ready) chk("send_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!a_out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!a_out_valid) chk(tag, 128'(0), 128'(1));
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic send_rand(input int mode);
        logic [N-1:0][DW-1:0] d;
        logic [N-1:0][IW-1:0] x;
        for (int i = 0; i < N; i++) begin
            d[i] = (mode == 0) ? DW'($urandom) : DW'($urandom_range(0, 3) * 16'h4001);
            x[i] = IW'($urandom);
        end
        send(1'($urandom), d, x);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 40000);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1 [N];
        int lat;
        int base;
        int seen;
        logic [N-1:0][DW-1:0] vd, ed;
        logic [N-1:0][IW-1:0] vx, ex;

        t1 = '{7, 3, 5, 1, 6, 2, 4, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_out_data",  128'(a_out_data),  128'(0));
        chk("rst_out_index", 128'(a_out_index), 128'(0));
        chk("rst_out_desc",  128'(a_out_desc),  128'(0));
        chk("rst_busy",      128'(a_busy),      128'(0));
        chk("rst_in_ready",  128'(a_in_ready),  128'(1));
        @(posedge clk);
        #1;

        // Same vector ascending then descending, back to back
        for (int i = 0; i < N; i++) begin
            vd[i] = DW'(t1[i]);
            vx[i] = IW'(i);
        end
        send(1'b0, vd, vx);
        base = acc_cyc;
        send(1'b1, vd, vx);
        wait_out("t1_timeout");
        lat = cyc - base + 1;
        chk("t1_latency", 128'(lat), 128'(6));
        for (int i = 0; i < N; i++) begin
            ed[i] = DW'(i);
            ex[i] = IW'(t1[i]);
        end
        chk("t1_data",  128'(a_out_data),  128'(ed));
        chk("t1_index", 128'(a_out_index), 128'(ex));
        chk("t1_desc",  128'(a_out_desc),  128'(0));
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ed[i] = DW'(N - 1 - i);
            ex[i] = IW'(t1[N-1-i]);
        end
        chk("t2_valid", 128'(a_out_valid), 128'(1));
        chk("t2_desc",  128'(a_out_desc),  128'(1));
        chk("t2_data",  128'(a_out_data),  128'(ed));
        chk("t2_index", 128'(a_out_index), 128'(ex));
        @(posedge clk);
        #1;

        // All-equal keys: index tie-break versus no swap
        t1 = '{3, 1, 2, 0, 7, 6, 5, 4};
        for (int i = 0; i < N; i++) begin
            vd[i] = DW'(5);
            vx[i] = IW'(t1[i]);
            ex[i] = IW'(i);
        end
        send(1'b0, vd, vx);
        wait_out("t3_timeout");
        chk("t3_tie_index",   128'(a_out_index), 128'(ex));
        chk("t3_notie_index", 128'(b_out_index), 128'(vx));
        @(posedge clk);
        #1;

        // Signed ordering
        vd = '0;
        vd[0] = 16'h8000;
        vd[1] = 16'h7FFF;
        vd[2] = 16'hFFFF;
        vd[3] = 16'h0000;
        for (int i = 4; i < N; i++) vd[i] = 16'h0001;
        for (int i = 0; i < N; i++) vx[i] = IW'(i);
        send(1'b0, vd, vx);
        wait_out("t4_timeout");
        chk("t4_lane0", 128'(c_out_data[0]), 128'(16'h8000));
        chk("t4_lane1", 128'(c_out_data[1]), 128'(16'hFFFF));
        chk("t4_lane7", 128'(c_out_data[7]), 128'(16'h7FFF));
        @(posedge clk);
        #1;
        drain("t4_drain");

        // Random stream with a 4-cycle downstream stall while full
        @(posedge clk);
        #1;
        base = n_out;
        fork
            begin
                for (int v = 0; v < 10; v++) send_rand(v % 2);
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("t5_drain");
        chk("t5_count", 128'(n_out - base), 128'(10));

        // Reset with two vectors in flight
        @(posedge clk);
        #1;
        send_rand(0);
        send_rand(1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy_pre", 128'(a_busy), 128'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 128'(a_out_valid), 128'(0));
        chk("t6_busy",      128'(a_busy),      128'(0));
        chk("t6_out_data",  128'(a_out_data),  128'(0));
        chk("t6_out_index", 128'(a_out_index), 128'(0));
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        chk("t6_no_ghost", 128'(seen), 128'(0));
        @(posedge clk);
        #1;
        base = n_out;
        send_rand(0);
        drain("t6_drain");
        chk("t6_after_count", 128'(n_out - base), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
- Fully pipelined bitonic sorting network. Sorts an N = 2**LOG_N lane vector of {data, index} pairs and accepts one new vector per cycle.
- Successor to the recursive ready/done comparison-merge blocks, adding four things:
  - valid/ready backpressure;
  - a per-vector runtime sort direction;
  - a deterministic tie-break;
  - signed compare.
- Sits between the correlator peak-collection buffer and the top-K selection logic in the sorting subsystem.

Parameters:
- LOG_N, 3: log2 of lane count N; N = 2**LOG_N; legal range 1..6.
- SIGNED, 0: 1 = data compared as two's complement; 0 = unsigned.
- TIE_INDEX, 1: 1 = equal data is ordered by index; 0 = equal data is never swapped.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector this cycle.
- in_desc  in  1  0 = ascending (lane 0 gets minimum), 1 = descending.
- in_data  in  [N-1:0][NETWORK_WIDTH-1:0]  keys.
- in_index  in  [N-1:0][INDEX_WIDTH-1:0]  payload travelling with each key.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output vector.
- out_desc  out  1  direction the output vector was sorted with.
- out_data  out  [N-1:0][NETWORK_WIDTH-1:0]  sorted keys.
- out_index  out  [N-1:0][INDEX_WIDTH-1:0]  payload permuted with the keys.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Stage count S = LOG_N*(LOG_N+1)/2.
  - Stages are ordered over k = 1..LOG_N, j = k-1 down to 0. Each (k, j) pair is one registered compare-exchange layer.
  - Stage s register holds: valid, desc, data[N], index[N].
- Pairing at stage (k, j):
  - Lane i with bit j clear pairs with lane p = i + 2**j.
  - The pair is ascending when bit k of i is 0 (or k == LOG_N), XOR desc.
- Compare rule: a (lane i) is "greater" than b (lane p) when:
  - data_a > data_b, signed or unsigned per SIGNED; or
  - TIE_INDEX = 1, data_a == data_b and index_a > index_b.
- Swap rule:
  - Ascending pair: swap when a is greater.
  - Descending pair: swap when b is greater.
  - Index always moves with its data.
- Advance:
  - advance = !out_valid || out_ready.
  - When advance = 1, every stage loads from its predecessor; stage 0 loads {in_valid, in_desc, in_data, in_index}.
  - When advance = 0, all stage registers hold.
  - No bubble collapsing; a global stall is required.
- in_ready = advance (combinational).
  - An input vector is accepted iff in_valid && in_ready.
  - in_valid = 1 with in_ready = 0 is not consumed; the source must hold its data stable.
- Stage valid bits are always written on advance. Data and index registers of an invalid slot may hold stale values.
- out_* is driven directly from stage S-1 registers.
- Latency: exactly S cycles from acceptance to out_valid, with no stall.
  - Throughput: 1 vector/cycle while out_ready = 1.
  - Output order equals input order.
- Stall: out_valid && !out_ready holds out_data, out_index and out_desc bit-stable until the handshake completes.
- Reset:
  - All valid bits clear to 0 and all data/index/desc registers clear to 0.
  - Therefore out_valid = 0, out_data = 0, out_index = 0, out_desc = 0, busy = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight vectors with no partial output.
  - Reset wins over a simultaneous in_valid or out_ready.
- Simultaneous output accept and input accept in one cycle is legal and loses no vectors.
- Direction is captured per vector: vectors with different in_desc may be back-to-back.
- LOG_N = 1 degenerates to a single registered comparator (S = 1).

Decomposition:
- Package sort_pkg:
  - function stage count S(LOG_N);
  - function key_greater(data_a, idx_a, data_b, idx_b, SIGNED, TIE_INDEX);
  - typedef sort_lane_t = struct {data[NETWORK_WIDTH], index[INDEX_WIDTH]}.
  - NETWORK_WIDTH and INDEX_WIDTH continue to come from the build parameter headers.
- Sub-module bitonic_layer #(LOG_N, K, J, SIGNED, TIE_INDEX):
  - purely combinational compare-exchange layer for one (k, j), taking desc.
  - The top level instantiates S of these in a generate loop and owns all registers and the advance logic.

Test Plan:
1. LOG_N=3, SIGNED=0, in_desc=0, data {7,3,5,1,6,2,4,0} (lane 0 first), index = lane, out_ready=1 -> out_valid exactly 6 cycles after acceptance; out_data {0,1,2,3,4,5,6,7}; out_index {7,3,5,1,6,2,4,0}.
2. Same vector with in_desc=1, back-to-back with test 1 -> two consecutive out_valid cycles: first ascending, then {7..0} with out_desc=1.
3. TIE_INDEX=1, data all 5, index {3,1,2,0,7,6,5,4}, ascending -> out_index {0..7}. With TIE_INDEX=0 -> out_index unchanged from input.
4. SIGNED=1, NETWORK_WIDTH=16, data {0x8000, 0x7FFF, 0xFFFF, 0, ...rest 1}, ascending -> lane 0 = 0x8000, lane 1 = 0xFFFF, lane 7 = 0x7FFF.
5. Stream 10 random vectors; hold out_ready=0 for 4 cycles while the pipe is full -> in_ready=0 during the stall; out_* stable; all 10 outputs match a golden sort, in order, with none dropped or duplicated.
6. Assert reset 3 cycles after accepting 2 vectors -> next cycle out_valid=0, busy=0, outputs 0; no output ever appears for the 2 discarded vectors; a vector accepted after reset completes normally.
